// File: rtl/conv_window_stream.sv
// Streaming KxK window generator over a K-row band, with level-sensitive replay of the
// stored band for extra output-channel passes.
module conv_window_stream #(
  parameter int unsigned DW     = 8,
  parameter int unsigned IMG_W  = 482,
  parameter int unsigned K      = 3,
  parameter int unsigned PASS_W = 8
) (
  input  logic                Rst_n,
  input  logic                clk,
  input  logic                clear,
  input  logic [DW-1:0]       din,
  input  logic                valid_in,
  output logic                in_ready,
  input  logic                repeat_in,
  output logic [K*K*DW-1:0]   win,
  output logic                win_valid,
  output logic                win_last,
  output logic [PASS_W-1:0]   pass_cnt,
  output logic                busy,
  output logic                err_drop
);

  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = $clog2(K);
  localparam int unsigned FW = $clog2(K + 1);

  typedef enum logic [0:0] {StIdle, StReplay} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      col_q;
  logic [RW-1:0]      wr_row_q;
  logic [FW-1:0]      rows_filled_q;
  logic [PASS_W-1:0]  pass_cnt_q;
  logic               win_valid_q, win_last_q, err_drop_q;
  logic [K*K*DW-1:0]  win_q, win_d;

  logic [DW-1:0]      mem [K][IMG_W];
  logic [DW-1:0]      new_col [K];
  logic [RW-1:0]      rd_row [K];

  logic replaying, load_beat, shift_en, col_last, emit, flush;

  assign flush     = !Rst_n || clear;
  assign replaying = (state_q == StReplay);
  assign load_beat = valid_in && in_ready;
  assign shift_en  = load_beat || replaying;
  assign col_last  = (col_q == CW'(IMG_W - 1));
  // Replay always owns a full band; loading needs K-1 completed rows above the live row.
  assign emit      = shift_en && (col_q >= CW'(K - 1)) &&
                     (replaying || (rows_filled_q >= FW'(K - 1)));

  // State register
  always_ff @(posedge clk) begin
    if (flush) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic; a beat on valid_in takes priority over a replay request
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (repeat_in && !valid_in && (col_q == '0) && (rows_filled_q == FW'(K)))
          state_d = StReplay;
      end
      StReplay: begin
        if (col_last && !repeat_in) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready = (state_q != StReplay);
    busy     = (state_q == StReplay);
  end

  // Oldest row sits at wr_row during replay; while loading, wr_row is the live row.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      rd_row[r]  = RW'((int'(wr_row_q) + r + (replaying ? 0 : 1)) % K);
      new_col[r] = mem[rd_row[r]][col_q];
    end
    if (!replaying) new_col[K-1] = din;
  end

  always_comb begin
    win_d = win_q;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_d[(r*K+c)*DW +: DW] = win_q[(r*K+c+1)*DW +: DW];
      end
      win_d[(r*K+K-1)*DW +: DW] = new_col[r];
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && load_beat) mem[wr_row_q][col_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      col_q         <= '0;
      wr_row_q      <= '0;
      rows_filled_q <= '0;
      pass_cnt_q    <= '0;
      win_q         <= '0;
      win_valid_q   <= 1'b0;
      win_last_q    <= 1'b0;
      err_drop_q    <= 1'b0;
    end else begin
      win_valid_q <= emit;
      win_last_q  <= emit && col_last;
      if (valid_in && !in_ready) err_drop_q <= 1'b1;
      if (shift_en) begin
        win_q <= win_d;
        col_q <= col_last ? '0 : col_q + 1'b1;
      end
      if (load_beat) begin
        if (col_q == '0) pass_cnt_q <= '0;
        if (col_last) begin
          wr_row_q <= (wr_row_q == RW'(K - 1)) ? '0 : wr_row_q + 1'b1;
          if (rows_filled_q != FW'(K)) rows_filled_q <= rows_filled_q + 1'b1;
        end
      end else if (replaying && col_last) begin
        pass_cnt_q <= pass_cnt_q + 1'b1;
      end
    end
  end

  assign win       = win_q;
  assign win_valid = win_valid_q;
  assign win_last  = win_last_q;
  assign pass_cnt  = pass_cnt_q;
  assign err_drop  = err_drop_q;

endmodule

// File: tb/tb_conv_window_stream.sv
// Randomised bench for conv_window_stream against a pixel-coordinate window model,
// plus literal expectations for the directed 8-wide, K=3 image.
module tb_conv_window_stream;

  localparam int unsigned DW     = 8;
  localparam int unsigned IMG_W  = 8;
  localparam int unsigned K      = 3;
  localparam int unsigned PASS_W = 2;
  localparam int unsigned WW     = K * K * DW;

  logic              clk = 1'b0;
  logic              Rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              valid_in = 1'b0;
  logic              repeat_in = 1'b0;
  logic [DW-1:0]     din = '0;
  logic              in_ready, win_valid, win_last, busy, err_drop;
  logic [WW-1:0]     win;
  logic [PASS_W-1:0] pass_cnt;

  always #5 clk = ~clk;

  conv_window_stream #(.DW(DW), .IMG_W(IMG_W), .K(K), .PASS_W(PASS_W)) dut (
    .clk       (clk),
    .Rst_n     (Rst_n),
    .clear     (clear),
    .din       (din),
    .valid_in  (valid_in),
    .in_ready  (in_ready),
    .repeat_in (repeat_in),
    .win       (win),
    .win_valid (win_valid),
    .win_last  (win_last),
    .pass_cnt  (pass_cnt),
    .busy      (busy),
    .err_drop  (err_drop)
  );

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [WW-1:0] pack(input int v [K*K]);
    logic [WW-1:0] p;
    p = '0;
    for (int i = 0; i < K * K; i++) p[i*DW +: DW] = DW'(v[i]);
    return p;
  endfunction

  // Model: band[K-1] is the newest completed row, cur is the row being loaded.
  logic [DW-1:0] band [K][IMG_W];
  logic [DW-1:0] cur [IMG_W];
  int            ccol = 0, nrows = 0, rc = 0, m_pass = 0;
  bit            m_rep = 1'b0, m_err = 1'b0;
  bit            e_valid = 1'b0, e_last = 1'b0;
  logic [WW-1:0] e_win = '0;

  task automatic model_step();
    e_valid = 1'b0;
    e_last  = 1'b0;
    if (!Rst_n || clear) begin
      ccol = 0; nrows = 0; rc = 0; m_pass = 0; m_rep = 1'b0; m_err = 1'b0; e_win = '0;
    end else if (m_rep) begin
      if (valid_in) m_err = 1'b1;
      if (rc >= K - 1) begin
        e_valid = 1'b1;
        e_last  = (rc == IMG_W - 1);
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++) e_win[(r*K+c)*DW +: DW] = band[r][rc-K+1+c];
      end
      rc++;
      if (rc == IMG_W) begin
        rc     = 0;
        m_pass = (m_pass + 1) % (1 << PASS_W);
        m_rep  = repeat_in;
      end
    end else if (valid_in) begin
      if (ccol == 0) m_pass = 0;
      cur[ccol] = din;
      if (nrows >= K - 1 && ccol >= K - 1) begin
        e_valid = 1'b1;
        e_last  = (ccol == IMG_W - 1);
        for (int c = 0; c < K; c++) begin
          for (int r = 0; r < K - 1; r++) e_win[(r*K+c)*DW +: DW] = band[r+1][ccol-K+1+c];
          e_win[((K-1)*K+c)*DW +: DW] = cur[ccol-K+1+c];
        end
      end
      if (ccol == IMG_W - 1) begin
        for (int r = 0; r < K - 1; r++) band[r] = band[r+1];
        band[K-1] = cur;
        ccol  = 0;
        nrows = (nrows + 1 > K) ? K : nrows + 1;
      end else begin
        ccol++;
      end
    end else if (repeat_in && ccol == 0 && nrows >= K) begin
      m_rep = 1'b1;
      rc    = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("win_valid", WW'(win_valid), WW'(e_valid));
      chk("win_last", WW'(win_last), WW'(e_last));
      chk("in_ready", WW'(in_ready), WW'(!m_rep));
      chk("busy", WW'(busy), WW'(m_rep));
      chk("pass_cnt", WW'(pass_cnt), WW'(m_pass));
      chk("err_drop", WW'(err_drop), WW'(m_err));
      if (e_valid) chk("win", win, e_win);
    end
  end

  task automatic pulse_repeat();
    @(negedge clk); repeat_in = 1'b1;
    @(negedge clk); repeat_in = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60 && busy; i++) @(negedge clk);
    chk(name, WW'(busy), WW'(0));
  endtask

  initial begin
    int lit [K*K];
    int busy_n, win_n;
    bit rep;

    @(negedge clk);
    chk_en = 1'b1;
    chk("reset_win", win, '0);
    chk("reset_in_ready", WW'(in_ready), WW'(1));
    @(negedge clk); Rst_n = 1'b1;

    for (int row = 0; row < 2; row++)
      for (int c = 0; c < IMG_W; c++) begin
        @(negedge clk); valid_in = 1'b1; din = DW'(row * 8 + c);
      end
    for (int c = 0; c < IMG_W; c++) begin
      @(negedge clk);
      if (c == 3) begin
        lit = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
        chk("first_window", win, pack(lit));
      end
      valid_in = 1'b1; din = DW'(16 + c);
    end
    @(negedge clk);
    lit = '{5, 6, 7, 13, 14, 15, 21, 22, 23};
    chk("last_window", win, pack(lit));
    chk("last_flag", WW'(win_last), WW'(1));
    valid_in = 1'b0;

    pulse_repeat();
    busy_n = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) busy_n++;
      @(negedge clk);
    end
    chk("busy_cycles", WW'(busy_n), WW'(8));
    chk("pass_after_pulse", WW'(pass_cnt), WW'(1));

    pulse_repeat();
    valid_in = 1'b1; din = 8'hAA;
    @(negedge clk); valid_in = 1'b0;
    chk("err_drop_set", WW'(err_drop), WW'(1));
    wait_idle("idle_after_drop");
    chk("pass_after_drop_pass", WW'(pass_cnt), WW'(2));

    @(negedge clk); repeat_in = 1'b1;
    win_n = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i == 15) repeat_in = 1'b0;
      if (win_valid) win_n++;
    end
    chk("hold_windows", WW'(win_n), WW'(12));
    wait_idle("idle_after_hold");
    chk("pass_wrap", WW'(pass_cnt), WW'(0));

    pulse_repeat();
    wait_idle("idle_after_pulse2");
    chk("pass_before_row3", WW'(pass_cnt), WW'(1));

    for (int c = 0; c < IMG_W; c++) begin
      @(negedge clk);
      if (c == 1) chk("pass_cleared_row3", WW'(pass_cnt), WW'(0));
      if (c == 3) begin
        lit = '{8, 9, 10, 16, 17, 18, 24, 25, 26};
        chk("row3_first_window", win, pack(lit));
        valid_in = 1'b0; repeat_in = 1'b1;
        @(negedge clk); repeat_in = 1'b0;
        chk("repeat_ignored", WW'(busy), WW'(0));
      end
      valid_in = 1'b1; din = DW'(24 + c);
    end
    @(negedge clk); valid_in = 1'b0;
    chk("err_drop_sticky", WW'(err_drop), WW'(1));

    for (int c = 0; c < 4; c++) begin
      @(negedge clk); valid_in = 1'b1; din = DW'($urandom);
    end
    @(negedge clk); valid_in = 1'b0; clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    chk("clear_err_drop", WW'(err_drop), WW'(0));
    chk("clear_win_valid", WW'(win_valid), WW'(0));

    rep = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      valid_in = ($urandom_range(9) < 7);
      din      = DW'($urandom);
      if ($urandom_range(19) == 0) rep = ~rep;
      repeat_in = rep;
      clear     = ($urandom_range(599) == 0);
      if (i == 1500) begin
        Rst_n = 1'b0;
        @(negedge clk); Rst_n = 1'b1;
      end
    end
    @(negedge clk);
    valid_in = 1'b0; repeat_in = 1'b0; clear = 1'b0;
    repeat (IMG_W * 3) @(negedge clk);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
